led_uart_reporter: RTL and testbench
====================================

LED_UART_REPORTER -- requirements
Module: led_uart_reporter

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200); SHALL be >= 2.
REQ-002 Parameter FIFO_DEPTH, default 4, bytes buffered between change detector and transmitter.
REQ-003 Clock  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 iLed  input  8  LED register value from the ALU's LED output.
REQ-006 oTx  output  1  UART 8N1 serial line, idle high.
REQ-007 oBusy  output  1  high while FIFO non-empty or a frame is in progress.
REQ-008 oOverflow  output  1  sticky flag, set when a detected change is dropped because the FIFO is full.
REQ-009 oFifoCount  output  3  current FIFO occupancy, 0..FIFO_DEPTH.

Function
REQ-010 Change detect: register rLast SHALL capture iLed every cycle; an enqueue request SHALL occur at edge E when iLed != rLast before E; enqueued data = iLed.
REQ-011 An unchanged value (iLed == rLast) SHALL produce no enqueue, even if the ALU rewrites the same value.
REQ-012 FIFO: circular buffer, FIFO_DEPTH entries, read/write pointers wrap modulo FIFO_DEPTH, strict FIFO order.
REQ-013 Full (count == FIFO_DEPTH) with no same-cycle pop: request SHALL be dropped, contents unchanged, oOverflow set to 1.
REQ-014 Full with a same-cycle pop: enqueue SHALL be accepted, count unchanged, oOverflow unaffected.
REQ-015 Empty with a same-cycle enqueue: no pop that cycle; the byte SHALL become visible to the transmitter on the next edge.
REQ-016 Transmitter FSM states: IDLE, START, DATA, STOP.
REQ-017 IDLE: oTx = 1; if count > 0, pop head into 8-bit shift register, clear baud counter, go to START.
REQ-018 START: oTx = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
REQ-019 DATA: oTx = shift-register bit 0 (LSB first); each bit lasts CLKS_PER_BIT cycles; after 8 bits go to STOP.
REQ-020 STOP: oTx = 1 for CLKS_PER_BIT cycles; at its final cycle, if count > 0, pop and go directly to START (zero idle gap); otherwise go to IDLE.
REQ-021 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles; baud counter 16 bits, counts 0..CLKS_PER_BIT-1.
REQ-022 Latency: iLed change sampled at edge E0 with transmitter IDLE and FIFO empty -> oTx falls after edge E0+1.
REQ-023 oTx SHALL be driven from a register (glitch-free).
REQ-024 oBusy = (state != IDLE) OR (count != 0), combinational from registered state.

Reset
REQ-025 Reset SHALL set: oTx = 1, state IDLE, shift register 0, baud counter 0, bit index 0, FIFO pointers and count 0, rLast = 8'h00, oOverflow = 0.
REQ-026 Reset mid-frame SHALL abort the frame (oTx high after the reset edge) and discard all FIFO contents.
REQ-027 Reset SHALL take priority over enqueue, pop and all FSM transitions in the same cycle.
REQ-028 oOverflow SHALL clear only on Reset.

Verification (CLKS_PER_BIT = 4, FIFO_DEPTH = 4)
REQ-029 Reset, iLed held 8'h00 for 100 cycles -> oTx = 1, oBusy = 0, oFifoCount = 0 throughout.
REQ-030 iLed 00->A5 sampled at E0 -> oTx low E1..E4, then data bits 1,0,1,0,0,1,0,1 (4 cycles each), stop high E37..E40; IDLE after E41, oBusy = 0.
REQ-031 iLed = 01,02,03,04,05,06 on edges E0..E5 -> 01 popped at E1; 02..05 fill FIFO (count 4 at E4); 06 dropped at E5, oOverflow = 1; serial output 01,02,03,04,05 back-to-back, no idle cycles between frames.
REQ-032 iLed rewritten with the same value (3C->3C) -> no additional frame; 3C->3D -> one frame carrying 3D.
REQ-033 Reset asserted mid-DATA of a frame with 2 bytes queued -> oTx = 1, oFifoCount = 0, oBusy = 0 after the reset edge; no further frames until a new iLed change.
REQ-034 FIFO full while a STOP ends, with a new change arriving on the same edge -> pop and push both occur, count stays 4, oOverflow stays 0.

Source files
------------

// File: rtl/led_uart_reporter.sv
// led_uart_reporter
//   Watches the ALU's LED register and sends every new value as one
//   UART 8N1 frame (LSB first, idle high). Changes are buffered in a
//   small circular FIFO so bursts of LED updates are not lost while a
//   frame is on the wire. If a change arrives while the FIFO is full and
//   no byte leaves that cycle, the change is dropped and a sticky
//   overflow flag is raised.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per UART bit (>= 2)
//   FIFO_DEPTH    bytes buffered between change detector and transmitter
//
// Ports
//   Clock       sole clock, rising edge
//   Reset       synchronous, active-high reset
//   iLed[7:0]   LED register value
//   oTx         UART serial line (registered, idle high)
//   oBusy       high while the FIFO holds data or a frame is in progress
//   oOverflow   sticky: a change was dropped because the FIFO was full
//   oFifoCount  current FIFO occupancy, 0..FIFO_DEPTH

module led_uart_reporter #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iLed,
    output logic       oTx,
    output logic       oBusy,
    output logic       oOverflow,
    output logic [2:0] oFifoCount
);

    localparam int               PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [2:0]       DEPTH_CNT = 3'(FIFO_DEPTH);
    localparam logic [15:0]      BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } txState_t;

    // Change detector and FIFO
    logic [7:0]       rLast;
    logic [7:0]       fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [2:0]       count;
    logic             pushReq;
    logic             push;
    logic             drop;

    // Transmitter
    txState_t    state;
    txState_t    stateNext;
    logic [15:0] baudCnt;
    logic [15:0] baudCntNext;
    logic [2:0]  bitIdx;
    logic [2:0]  bitIdxNext;
    logic [7:0]  shiftReg;
    logic [7:0]  shiftRegNext;
    logic        txReg;
    logic        txNext;
    logic        pop;
    logic        baudDone;

    assign pushReq  = (iLed != rLast);
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push     = pushReq && ((count != DEPTH_CNT) || pop);
    assign drop     = pushReq && (count == DEPTH_CNT) && !pop;
    assign baudDone = (baudCnt == BAUD_LAST);

    // Next-state and next-output logic. oTx is registered, so txNext is
    // the line level belonging to the state being entered.
    always_comb begin
        stateNext    = state;
        baudCntNext  = baudCnt;
        bitIdxNext   = bitIdx;
        shiftRegNext = shiftReg;
        txNext       = txReg;
        pop          = 1'b0;

        case (state)
            IDLE: begin
                txNext = 1'b1;
                if (count != '0) begin
                    pop          = 1'b1;
                    shiftRegNext = fifoMem[rdPtr];
                    baudCntNext  = '0;
                    stateNext    = START;
                    txNext       = 1'b0;
                end
            end
            START: begin
                if (baudDone) begin
                    baudCntNext = '0;
                    bitIdxNext  = '0;
                    stateNext   = DATA;
                    txNext      = shiftReg[0];
                end else begin
                    baudCntNext = baudCnt + 16'd1;
                end
            end
            DATA: begin
                if (baudDone) begin
                    baudCntNext = '0;
                    if (bitIdx == 3'd7) begin
                        stateNext = STOP;
                        txNext    = 1'b1;
                    end else begin
                        // Shift first; the next bit out is the new bit 0.
                        bitIdxNext   = bitIdx + 3'd1;
                        shiftRegNext = shiftReg >> 1;
                        txNext       = shiftReg[1];
                    end
                end else begin
                    baudCntNext = baudCnt + 16'd1;
                end
            end
            STOP: begin
                if (baudDone) begin
                    baudCntNext = '0;
                    if (count != '0) begin
                        // Back-to-back frames: no idle bit between them.
                        pop          = 1'b1;
                        shiftRegNext = fifoMem[rdPtr];
                        stateNext    = START;
                        txNext       = 1'b0;
                    end else begin
                        stateNext = IDLE;
                        txNext    = 1'b1;
                    end
                end else begin
                    baudCntNext = baudCnt + 16'd1;
                end
            end
            default: begin
                stateNext = IDLE;
                txNext    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            baudCnt   <= '0;
            bitIdx    <= '0;
            shiftReg  <= '0;
            txReg     <= 1'b1;
            rLast     <= 8'h00;
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            oOverflow <= 1'b0;
        end else begin
            state    <= stateNext;
            baudCnt  <= baudCntNext;
            bitIdx   <= bitIdxNext;
            shiftReg <= shiftRegNext;
            txReg    <= txNext;
            rLast    <= iLed;

            if (push) begin
                wrPtr <= (wrPtr == PTR_LAST) ? '0 : wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= (rdPtr == PTR_LAST) ? '0 : rdPtr + 1'b1;
            end

            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase

            if (drop) begin
                oOverflow <= 1'b1;
            end
        end
    end

    // Storage has no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge Clock) begin
        if (!Reset && push) begin
            fifoMem[wrPtr] <= iLed;
        end
    end

    assign oTx        = txReg;
    assign oBusy      = (state != IDLE) || (count != '0);
    assign oFifoCount = count;

endmodule

// File: tb/tb_led_uart_reporter.sv
// tb_led_uart_reporter
//   Self-checking bench for led_uart_reporter (CLKS_PER_BIT = 4,
//   FIFO_DEPTH = 4). A queue-based model predicts the serial line from
//   frame start time and byte value; it is compared with the DUT on
//   every falling edge, and directed scenarios add literal checks.

module tb_led_uart_reporter;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk;
    logic       Reset;
    logic [7:0] iLed;
    logic       oTx;
    logic       oBusy;
    logic       oOverflow;
    logic [2:0] oFifoCount;

    int checks = 0;
    int errors = 0;

    led_uart_reporter #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .Clock     (clk),
        .Reset     (Reset),
        .iLed      (iLed),
        .oTx       (oTx),
        .oBusy     (oBusy),
        .oOverflow (oOverflow),
        .oFifoCount(oFifoCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic waitN(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: pending bytes, and the byte on the wire with its elapsed cycles.
    logic [7:0] q[$];
    logic [7:0] frameByte;
    logic [7:0] prevLed;
    int         phase;
    bit         txActive;
    bit         expOvf;
    bit         modelValid = 1'b0;
    bit         popNow;

    always @(posedge clk) begin
        if (Reset) begin
            q.delete();
            txActive   = 1'b0;
            phase      = 0;
            expOvf     = 1'b0;
            prevLed    = 8'h00;
            modelValid = 1'b1;
        end else if (modelValid) begin
            popNow = 1'b0;
            if (!txActive || phase == FRAME - 1) begin
                if (q.size() > 0) popNow = 1'b1;
                else              txActive = 1'b0;
            end else begin
                phase++;
            end
            if (iLed != prevLed) begin
                if (q.size() == DEPTH && !popNow) expOvf = 1'b1;
                else                              q.push_back(iLed);
            end
            if (popNow) begin
                frameByte = q.pop_front();
                phase     = 0;
                txActive  = 1'b1;
            end
            prevLed = iLed;
        end
    end

    function automatic int expTx();
        int slot;
        if (!txActive) return 1;
        slot = phase / CPB;
        if (slot == 0) return 0;
        if (slot == 9) return 1;
        return int'(frameByte[slot-1]);
    endfunction

    always @(negedge clk) begin
        if (modelValid) begin
            check("tx",       int'(oTx),        expTx());
            check("busy",     int'(oBusy),      int'(txActive || q.size() != 0));
            check("overflow", int'(oOverflow),  int'(expOvf));
            check("count",    int'(oFifoCount), q.size());
        end
    end

    // Line level expected at mid-slot for A5: start, 1,0,1,0,0,1,0,1, stop.
    int slotA5[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    initial begin
        Reset = 1'b1;
        iLed  = 8'h00;
        waitN(3);
        Reset = 1'b0;

        // Quiet line with unchanged LEDs
        waitN(100);
        check("quiet_tx",    int'(oTx),        1);
        check("quiet_busy",  int'(oBusy),      0);
        check("quiet_count", int'(oFifoCount), 0);

        // Single frame 00 -> A5
        iLed = 8'hA5;
        waitN(3);
        check("a5_slot0", int'(oTx), slotA5[0]);
        for (int j = 1; j < 10; j++) begin
            waitN(4);
            check($sformatf("a5_slot%0d", j), int'(oTx), slotA5[j]);
        end
        waitN(3);
        check("a5_idle_busy", int'(oBusy), 0);
        check("a5_idle_tx",   int'(oTx),   1);

        // Burst 01..06: FIFO fills, 06 is dropped
        waitN(5);
        for (int i = 1; i <= 6; i++) begin
            iLed = 8'(i);
            waitN(1);
            if (i == 5) check("burst_full_count", int'(oFifoCount), 4);
            if (i == 6) begin
                check("burst_ovf",        int'(oOverflow),  1);
                check("burst_drop_count", int'(oFifoCount), 4);
            end
        end
        waitN(200);
        check("burst_drained", int'(oBusy), 0);

        // Reset in the middle of a frame with two bytes queued
        waitN(5);
        iLed = 8'h11;
        waitN(1);
        iLed = 8'h22;
        waitN(1);
        iLed = 8'h33;
        waitN(1);
        check("mid_queued", int'(oFifoCount), 2);
        waitN(12);
        Reset = 1'b1;
        iLed  = 8'h00;
        waitN(1);
        check("rst_tx",    int'(oTx),        1);
        check("rst_count", int'(oFifoCount), 0);
        check("rst_busy",  int'(oBusy),      0);
        Reset = 1'b0;
        waitN(60);
        check("rst_quiet_busy", int'(oBusy),     0);
        check("rst_ovf_clear",  int'(oOverflow), 0);

        // Same value rewritten sends nothing; a real change sends one frame
        iLed = 8'h3C;
        waitN(50);
        iLed = 8'h3C;
        waitN(20);
        check("same_busy", int'(oBusy), 0);
        iLed = 8'h3D;
        waitN(2);
        check("3d_start", int'(oTx), 0);
        waitN(48);
        check("3d_done", int'(oBusy), 0);

        // Full FIFO at the end of STOP with a change on the same edge
        iLed = 8'h41;
        waitN(1);
        iLed = 8'h42;
        waitN(1);
        iLed = 8'h43;
        waitN(1);
        iLed = 8'h44;
        waitN(1);
        iLed = 8'h45;
        waitN(1);
        check("full_count", int'(oFifoCount), 4);
        waitN(36);
        iLed = 8'h46;
        waitN(1);
        check("swap_count", int'(oFifoCount), 4);
        check("swap_ovf",   int'(oOverflow),  0);
        check("swap_start", int'(oTx),        0);
        waitN(220);
        check("swap_drained", int'(oBusy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
